// File: rtl/alu_control_mdu_if.sv
// rtl/alu_control_mdu_if.sv - decode/multiply-divide bundle between the core and alu_control_mdu
//  master : core side, drives decode fields, instr_vld and operands; receives Operation, Con_*, md_*
//  slave  : alu_control_mdu side
interface alu_control_mdu_if #(
    parameter int XLEN = 32
);
    logic [1:0]      ALUOp;
    logic [6:0]      Funct7;
    logic [2:0]      Funct3;
    logic            Branch;
    logic            Mem;
    logic            OpI;
    logic            instr_vld;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [3:0]      Operation;
    logic            Con_beq;
    logic            Con_bnq;
    logic            Con_blt;
    logic            Con_bgt;
    logic            md_stall;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    modport master (
        output ALUOp, Funct7, Funct3, Branch, Mem, OpI, instr_vld, rs1, rs2,
        input  Operation, Con_beq, Con_bnq, Con_blt, Con_bgt, md_stall, md_done, md_result
    );

    modport slave (
        input  ALUOp, Funct7, Funct3, Branch, Mem, OpI, instr_vld, rs1, rs2,
        output Operation, Con_beq, Con_bnq, Con_blt, Con_bgt, md_stall, md_done, md_result
    );
endinterface

// File: rtl/alu_control_mdu.sv
// rtl/alu_control_mdu.sv - ALU control decode plus iterative RV32M multiply/divide sequencer
//  clk, reset : rising-edge clock, synchronous active-high reset
//  bus        : slave side of alu_control_mdu_if
//               decode in (ALUOp/Funct7/Funct3/Branch/Mem/OpI) -> Operation, Con_* (combinational)
//               instr_vld, rs1, rs2 -> md_stall (stall core), md_done (1-cycle pulse), md_result
module alu_control_mdu #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic          clk,
    input  logic          reset,
    alu_control_mdu_if.slave bus
);
    localparam int N  = XLEN / UNROLL;
    localparam int CW = $clog2(N) + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1100;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;        // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;        // multiplier (shifted out) / dividend -> quotient
    logic [XLEN-1:0] b_q, b_d;          // multiplicand / divisor magnitude
    logic [2:0]      f3_q, f3_d;
    logic            neg_q, neg_d;      // product or quotient must be negated
    logic            rneg_q, rneg_d;    // remainder must be negated
    logic            spec_q, spec_d;    // divide-by-zero or signed overflow
    logic [XLEN-1:0] spec_res_q, spec_res_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] result_q, result_d;

    logic m_op, md_start;
    logic s1, s2, neg1, neg2, dz, ovf;
    logic [XLEN-1:0]   mag1, mag2;
    logic [XLEN-1:0]   hi_n, lo_n;
    logic [XLEN:0]     sum, sh;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   q_s, r_s, mul_res, div_res;

    assign m_op     = (bus.ALUOp == 2'b10) && !bus.OpI && (bus.Funct7 == 7'b0000001);
    assign md_start = bus.instr_vld && m_op && (state_q == S_IDLE);

    // ALU operation decode
    always_comb begin
        bus.Operation = OP_ADD;
        if (bus.Mem) begin
            bus.Operation = OP_ADD;
        end else if (bus.Branch) begin
            // unsigned compares (BLTU/BGEU) need SLTU, everything else subtracts
            bus.Operation = (bus.Funct3[2:1] == 2'b11) ? OP_SLTU : OP_SUB;
        end else if (bus.OpI || (bus.ALUOp == 2'b10 && !m_op)) begin
            case (bus.Funct3)
                3'b000:  bus.Operation = (!bus.OpI && bus.Funct7 == 7'b0100000) ? OP_SUB : OP_ADD;
                3'b001:  bus.Operation = OP_SLL;
                3'b010:  bus.Operation = OP_SLT;
                3'b011:  bus.Operation = OP_SLTU;
                3'b100:  bus.Operation = OP_XOR;
                3'b101:  bus.Operation = (bus.Funct7 == 7'b0100000) ? OP_SRA : OP_SRL;
                3'b110:  bus.Operation = OP_OR;
                default: bus.Operation = OP_AND;
            endcase
        end else if (bus.ALUOp == 2'b01) begin
            bus.Operation = OP_SUB;
        end
    end

    assign bus.Con_beq = bus.Branch && (bus.Funct3 == 3'b000);
    assign bus.Con_bnq = bus.Branch && (bus.Funct3 == 3'b001);
    assign bus.Con_blt = bus.Branch && (bus.Funct3 == 3'b100 || bus.Funct3 == 3'b110);
    assign bus.Con_bgt = bus.Branch && (bus.Funct3 == 3'b101 || bus.Funct3 == 3'b111);

    // Operand conditioning at start: f3[2]=1 is a divide, signed when f3[0]=0;
    // multiplies treat rs1 signed except MULHU, rs2 signed only for MUL/MULH.
    always_comb begin
        s1   = bus.Funct3[2] ? !bus.Funct3[0] : (bus.Funct3[1:0] != 2'b11);
        s2   = bus.Funct3[2] ? !bus.Funct3[0] : !bus.Funct3[1];
        neg1 = s1 && bus.rs1[XLEN-1];
        neg2 = s2 && bus.rs2[XLEN-1];
        mag1 = neg1 ? (~bus.rs1 + 1'b1) : bus.rs1;
        mag2 = neg2 ? (~bus.rs2 + 1'b1) : bus.rs2;
        dz   = (bus.rs2 == '0);
        ovf  = s1 && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
        if (bus.Funct3[1]) spec_res_d = dz ? bus.rs1 : '0;
        else               spec_res_d = dz ? '1 : bus.rs1;
    end

    // UNROLL shift-add or restoring-divide steps per cycle
    always_comb begin
        hi_n = hi_q;
        lo_n = lo_q;
        sum  = '0;
        sh   = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (state_q == S_MUL) begin
                sum  = {1'b0, hi_n} + (lo_n[0] ? {1'b0, b_q} : '0);
                lo_n = {sum[0], lo_n[XLEN-1:1]};
                hi_n = sum[XLEN:1];
            end else begin
                sh = {hi_n, lo_n[XLEN-1]};
                if (sh >= {1'b0, b_q}) begin
                    sh   = sh - {1'b0, b_q};
                    lo_n = {lo_n[XLEN-2:0], 1'b1};
                end else begin
                    lo_n = {lo_n[XLEN-2:0], 1'b0};
                end
                hi_n = sh[XLEN-1:0];
            end
        end
        prod    = {hi_n, lo_n};
        prod_s  = neg_q ? (~prod + 1'b1) : prod;
        mul_res = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        q_s     = neg_q ? (~lo_n + 1'b1) : lo_n;
        r_s     = rneg_q ? (~hi_n + 1'b1) : hi_n;
        div_res = f3_q[1] ? r_s : q_s;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        spec_d   = spec_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (md_start) begin
                    state_d = bus.Funct3[2] ? S_DIV : S_MUL;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = mag1;
                    b_d     = mag2;
                    f3_d    = bus.Funct3;
                    neg_d   = neg1 ^ neg2;
                    rneg_d  = neg1;
                    spec_d  = bus.Funct3[2] && (dz || ovf);
                end
            end
            S_MUL, S_DIV: begin
                if (state_q == S_DIV && spec_q) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = spec_res_q;
                end else begin
                    hi_d  = hi_n;
                    lo_d  = lo_n;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = (state_q == S_MUL) ? mul_res : div_res;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            b_q        <= '0;
            f3_q       <= '0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            spec_q   <= spec_d;
            // special result only captured on start so later operand changes cannot disturb it
            if (md_start) spec_res_q <= spec_res_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.md_stall  = md_start || (state_q == S_MUL) || (state_q == S_DIV);
    assign bus.md_done   = done_q;
    assign bus.md_result = result_q;
endmodule
